avalon_burst_splitter: RTL and testbench

//  Upstream stage of the Avalon-to-Wishbone bridge.

---
 rtl/avalon_burst_splitter.sv | 89 ++++++++
 tb/tb_avalon_burst_splitter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_splitter.sv
// avalon_burst_splitter: turns Avalon-MM read/write bursts into single-beat accesses with incrementing addresses
module avalon_burst_splitter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int BURST_W = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [AW-1:0]      s_av_address_i,
    input  logic [DW/8-1:0]    s_av_byteenable_i,
    input  logic [BURST_W-1:0] s_av_burstcount_i,
    input  logic               s_av_read_i,
    input  logic               s_av_write_i,
    input  logic [DW-1:0]      s_av_writedata_i,
    output logic               s_av_waitrequest_o,
    output logic [DW-1:0]      s_av_readdata_o,
    output logic               s_av_readdatavalid_o,
    output logic [AW-1:0]      m_av_address_o,
    output logic [DW/8-1:0]    m_av_byteenable_o,
    output logic [BURST_W-1:0] m_av_burstcount_o,
    output logic               m_av_read_o,
    output logic               m_av_write_o,
    output logic [DW-1:0]      m_av_writedata_o,
    input  logic               m_av_waitrequest_i,
    input  logic [DW-1:0]      m_av_readdata_i,
    input  logic               m_av_readdatavalid_i
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_ISSUE = 2'd1;
    localparam logic [1:0] RD_DRAIN = 2'd2;
    localparam logic [1:0] WR       = 2'd3;
    localparam logic [AW-1:0] STEP = AW'(DW/8);
    localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

    logic [1:0]         state, state_nxt;
    logic [AW-1:0]      addr_reg;
    logic [DW/8-1:0]    be_reg;
    logic [BURST_W-1:0] issue_cnt, resp_cnt, beats;
    logic               rd_fire, wr_fire, rsp;

    always_comb begin
        beats   = (s_av_burstcount_i == '0) ? ONE : s_av_burstcount_i;
        rd_fire = (state == RD_ISSUE) && !m_av_waitrequest_i;
        wr_fire = (state == WR) && s_av_write_i && !m_av_waitrequest_i;
        rsp     = ((state == RD_ISSUE) || (state == RD_DRAIN)) && m_av_readdatavalid_i;
        state_nxt = (state == IDLE)     ? (s_av_read_i ? RD_ISSUE : s_av_write_i ? WR : IDLE) :
                    (state == RD_ISSUE) ? ((rd_fire && issue_cnt == ONE) ? RD_DRAIN : RD_ISSUE) :
                    (state == RD_DRAIN) ? ((resp_cnt == '0) ? IDLE : RD_DRAIN) :
                                          ((wr_fire && issue_cnt == ONE) ? IDLE : WR);
    end

    // Outputs are forced quiet while reset is held, even mid-burst
    assign s_av_waitrequest_o   = wb_rst_i || ((state == IDLE) ? !s_av_read_i :
                                               (state == WR)   ? m_av_waitrequest_i : 1'b1);
    assign s_av_readdata_o      = m_av_readdata_i;
    assign s_av_readdatavalid_o = rsp && !wb_rst_i;
    assign m_av_address_o       = addr_reg;
    assign m_av_byteenable_o    = (state == WR) ? s_av_byteenable_i : be_reg;
    assign m_av_burstcount_o    = ONE;
    assign m_av_read_o          = (state == RD_ISSUE) && !wb_rst_i;
    assign m_av_write_o         = (state == WR) && s_av_write_i && !wb_rst_i;
    assign m_av_writedata_o     = s_av_writedata_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            addr_reg  <= '0;
            be_reg    <= '0;
            issue_cnt <= '0;
            resp_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (s_av_read_i || s_av_write_i)) begin
                addr_reg  <= s_av_address_i;
                issue_cnt <= beats;
                if (s_av_read_i) begin
                    be_reg   <= s_av_byteenable_i;
                    resp_cnt <= beats;
                end
            end
            if (rd_fire || wr_fire) begin
                addr_reg  <= addr_reg + STEP;
                issue_cnt <= issue_cnt - ONE;
            end
            if (rsp && resp_cnt != '0)
                resp_cnt <= resp_cnt - ONE;
        end
    end
endmodule

// File: tb/tb_avalon_burst_splitter.sv
// tb_avalon_burst_splitter: table-driven bursts against a bridge model, with a scoreboard of expected beats
module tb_avalon_burst_splitter;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [31:0] s_av_address_i = '0;
    logic [3:0]  s_av_byteenable_i = '0;
    logic [7:0]  s_av_burstcount_i = '0;
    logic        s_av_read_i = 1'b0;
    logic        s_av_write_i = 1'b0;
    logic [31:0] s_av_writedata_i = '0;
    logic        s_av_waitrequest_o;
    logic [31:0] s_av_readdata_o;
    logic        s_av_readdatavalid_o;
    logic [31:0] m_av_address_o;
    logic [3:0]  m_av_byteenable_o;
    logic [7:0]  m_av_burstcount_o;
    logic        m_av_read_o;
    logic        m_av_write_o;
    logic [31:0] m_av_writedata_o;
    logic        m_av_waitrequest_i = 1'b0;
    logic [31:0] m_av_readdata_i = '0;
    logic        m_av_readdatavalid_i = 1'b0;

    always #5 wb_clk_i = ~wb_clk_i;

    avalon_burst_splitter #(.DW(32), .AW(32), .BURST_W(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .s_av_address_i(s_av_address_i), .s_av_byteenable_i(s_av_byteenable_i),
        .s_av_burstcount_i(s_av_burstcount_i), .s_av_read_i(s_av_read_i),
        .s_av_write_i(s_av_write_i), .s_av_writedata_i(s_av_writedata_i),
        .s_av_waitrequest_o(s_av_waitrequest_o), .s_av_readdata_o(s_av_readdata_o),
        .s_av_readdatavalid_o(s_av_readdatavalid_o), .m_av_address_o(m_av_address_o),
        .m_av_byteenable_o(m_av_byteenable_o), .m_av_burstcount_o(m_av_burstcount_o),
        .m_av_read_o(m_av_read_o), .m_av_write_o(m_av_write_o),
        .m_av_writedata_o(m_av_writedata_o), .m_av_waitrequest_i(m_av_waitrequest_i),
        .m_av_readdata_i(m_av_readdata_i), .m_av_readdatavalid_i(m_av_readdatavalid_i)
    );

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] be; } cmd_t;
    typedef struct { logic [31:0] data; int due; } rsp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [7:0] bc; logic [3:0] be; logic [11:0] wbe; int stall; int beats; } vec_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_rd[$];
    rsp_t        pend[$];
    vec_t        tbl[7];
    int n_cmp = 0, n_bad = 0, cyc = 0, cmd_seen = 0, rsp_seen = 0, stall_mode = 0;
    bit stalled = 1'b0;
    logic smp_wait, smp_rdv, smp_mrd, smp_mwr;
    logic [31:0] smp_addr;
    logic [7:0]  smp_bc;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] wdata(input int idx, input int i);
        return 32'hD000_0000 | 32'(idx << 8) | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One clock of the bridge model plus scoreboard checks; entered and left at a falling edge
    task automatic cycle();
        bit req, acc;
        cmd_t c;
        m_av_readdatavalid_i = 1'b0;
        m_av_readdata_i = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            m_av_readdatavalid_i = 1'b1;
            m_av_readdata_i = pend[0].data;
        end
        #1;
        req = m_av_read_o || m_av_write_o;
        m_av_waitrequest_i = (stall_mode == 0) ? 1'b0 :
                             (stall_mode == 1) ? (req && !stalled) : 1'($urandom_range(0, 1));
        #1;
        acc = req && !m_av_waitrequest_i;
        smp_wait = s_av_waitrequest_o; smp_rdv = s_av_readdatavalid_o;
        smp_mrd = m_av_read_o; smp_mwr = m_av_write_o;
        smp_addr = m_av_address_o; smp_bc = m_av_burstcount_o;
        if (acc) begin
            cmd_seen++;
            if (exp_cmd.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_cmd: got wr=%0b addr %0h, required no access", m_av_write_o, m_av_address_o);
            end else begin
                c = exp_cmd.pop_front();
                chk("cmd_kind", m_av_write_o, c.wr);
                chk("cmd_addr", m_av_address_o, c.addr);
                chk("cmd_be", m_av_byteenable_o, c.be);
                chk("burstcount", m_av_burstcount_o, 1);
                if (c.wr) chk("cmd_wdata", m_av_writedata_o, c.data);
            end
            if (m_av_read_o) pend.push_back('{rd_val(m_av_address_o), cyc + 2});
        end
        if (s_av_readdatavalid_o) begin
            rsp_seen++;
            if (exp_rd.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_rdata: got %0h, required no response", s_av_readdata_o);
            end else
                chk("rdata", s_av_readdata_o, exp_rd.pop_front());
        end
        stalled = req && !acc;
        @(posedge wb_clk_i);
        if (m_av_readdatavalid_i) void'(pend.pop_front());
        cyc++;
        @(negedge wb_clk_i);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, n, beat;
        cmd_t c;
        logic [31:0] a;
        stall_mode = v.stall; cmd_seen = 0; rsp_seen = 0;
        for (int i = 0; i < v.beats; i++) begin
            a = v.addr + 32'(4 * i);
            c.wr = v.wr; c.addr = a; c.data = wdata(idx, i);
            c.be = v.wr ? v.wbe[i*4 +: 4] : v.be;
            exp_cmd.push_back(c);
            if (!v.wr) exp_rd.push_back(rd_val(a));
        end
        s_av_address_i = v.addr; s_av_burstcount_i = v.bc;
        if (!v.wr) begin
            s_av_read_i = 1'b1; s_av_byteenable_i = v.be; lat = 0;
            do begin cycle(); lat++; end while (smp_wait && lat < 50);
            s_av_read_i = 1'b0; s_av_address_i = 32'hDEAD_BEEF;
            s_av_burstcount_i = 8'd9; s_av_byteenable_i = 4'h0;
            chk($sformatf("v%0d_accept_lat", idx), lat, 1);
            n = 0;
            while (rsp_seen < v.beats && n < 200) begin cycle(); n++; end
        end else begin
            beat = 0; n = 0;
            while (beat < v.beats && n < 200) begin
                s_av_write_i = (v.stall == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_av_writedata_i = wdata(idx, beat);
                s_av_byteenable_i = v.wbe[beat*4 +: 4];
                cycle(); n++;
                if (s_av_write_i && !smp_wait) beat++;
            end
            s_av_write_i = 1'b0;
        end
        repeat (3) cycle();
        chk($sformatf("v%0d_cmds", idx), cmd_seen, v.beats);
        if (!v.wr) chk($sformatf("v%0d_rsps", idx), rsp_seen, v.beats);
        chk($sformatf("v%0d_cmd_q_empty", idx), exp_cmd.size(), 0);
        exp_cmd.delete(); exp_rd.delete();
    endtask

    initial begin
        int n;
        cmd_t c;
        //         wr  addr           bc    be    wbe      stall beats
        tbl[0] = '{0, 32'h0000_0100, 8'd1, 4'hF, 12'h000, 0,    1};
        tbl[1] = '{0, 32'h0000_1000, 8'd4, 4'hF, 12'h000, 1,    4};
        tbl[2] = '{1, 32'h0000_0200, 8'd3, 4'h0, 12'hC3F, 2,    3};
        tbl[3] = '{0, 32'h0000_0400, 8'd0, 4'h5, 12'h000, 0,    1};
        tbl[4] = '{0, 32'hFFFF_FFFC, 8'd2, 4'hF, 12'h000, 1,    2};
        tbl[5] = '{1, 32'h0000_0800, 8'd2, 4'h0, 12'h069, 1,    2};
        tbl[6] = '{0, 32'h0000_2000, 8'd5, 4'h3, 12'h000, 2,    5};

        // Reset with a read request and a stray response present: nothing may pass
        s_av_read_i = 1'b1;
        pend.push_back('{32'h1234_5678, 0});
        pend.push_back('{32'h8765_4321, 0});
        cycle(); cycle();
        chk("rst_wait", smp_wait, 1);
        chk("rst_mrd", smp_mrd, 0);
        chk("rst_mwr", smp_mwr, 0);
        chk("rst_rdv", smp_rdv, 0);
        wb_rst_i = 1'b0; s_av_read_i = 1'b0;
        cycle();
        chk("idle_addr", smp_addr, 0);
        chk("idle_bc", smp_bc, 1);
        chk("idle_wait", smp_wait, 1);
        chk("idle_mrd", smp_mrd, 0);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

        // Reset after two of four read responses; late responses must be dropped
        stall_mode = 0; cmd_seen = 0; rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            c.wr = 1'b0; c.addr = 32'h3000 + 32'(4 * i); c.be = 4'hF; c.data = '0;
            exp_cmd.push_back(c);
            if (i < 2) exp_rd.push_back(rd_val(c.addr));
        end
        s_av_address_i = 32'h3000; s_av_burstcount_i = 8'd4; s_av_byteenable_i = 4'hF;
        s_av_read_i = 1'b1; n = 0;
        do begin cycle(); n++; end while (smp_wait && n < 50);
        s_av_read_i = 1'b0;
        n = 0;
        while (rsp_seen < 2 && n < 50) begin cycle(); n++; end
        chk("rstmid_rsps_before", rsp_seen, 2);
        chk("rstmid_cmds", cmd_seen, 4);
        wb_rst_i = 1'b1;
        cycle();
        chk("rstmid_mrd", smp_mrd, 0);
        chk("rstmid_rdv", smp_rdv, 0);
        wb_rst_i = 1'b0;
        repeat (4) cycle();
        chk("rstmid_rsps_after", rsp_seen, 2);
        chk("rstmid_late_delivered", pend.size(), 0);
        chk("rstmid_cmd_q_empty", exp_cmd.size(), 0);
        exp_cmd.delete(); exp_rd.delete();
        run_vec(tbl[1], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
